// File: rtl/freq_div_pkg.sv
// Shared timing constants for the clock-enable frequency dividers.
// Every divider instance takes its default divisor/counter width from here.
package freq_div_pkg;

  localparam int unsigned FREQ_DIV_N_WIDTH = 16;

endpackage

// File: rtl/freq_div.sv
// Programmable divider: 50 % duty square wave with period 2*(N+1) clk cycles.
// The divisor is latched at reset and at each half-period wrap only.
module freq_div
  import freq_div_pkg::*;
#(
  parameter int unsigned N_WIDTH = FREQ_DIV_N_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_WIDTH-1:0] N,
  output logic               out
);

  logic [N_WIDTH-1:0] count;
  logic [N_WIDTH-1:0] n_act;

  // Wrap via compare against the latched divisor, so an all-ones divisor
  // never relies on counter overflow and mid-period N changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      out   <= 1'b0;
      n_act <= N;
    end else if (count == n_act) begin
      count <= '0;
      out   <= ~out;
      n_act <= N;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_freq_div.sv
// Scoreboard bench for freq_div: eight concurrent instances (seven 16-bit, one 4-bit)
// checked against a segment-based waveform model under directed and random stimulus.
module tb_freq_div;

  localparam int unsigned NI = 8;

  typedef struct {
    int unsigned idx;
    bit          val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst  [NI];
  logic [15:0] nv   [NI];
  logic        dout [NI];
  logic [3:0]  n_small;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  exp_t        exp_q[$];
  int unsigned seg_left [NI];
  bit          level    [NI];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 7; g++) begin : g_w16
      freq_div #(.N_WIDTH(16)) u_div (
        .clk   (clk),
        .reset (rst[g]),
        .N     (nv[g]),
        .out   (dout[g])
      );
    end
  endgenerate

  assign n_small = nv[7][3:0];

  freq_div #(.N_WIDTH(4)) u_div_w4 (
    .clk   (clk),
    .reset (rst[7]),
    .N     (n_small),
    .out   (dout[7])
  );

  // Reference: the output is a sequence of constant-level segments. A segment
  // starts at a reset edge (level 0) or when the previous segment is used up
  // (level flips); its length is N+1 using N as sampled on its first edge.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int unsigned n_now;
      exp_t        e;
      n_now = (i == NI - 1) ? 32'(nv[i][3:0]) : 32'(nv[i]);
      if (rst[i] !== 1'b1) begin
        level[i]    = 1'b0;
        seg_left[i] = n_now + 1;
      end else if (seg_left[i] == 0) begin
        level[i]    = ~level[i];
        seg_left[i] = n_now + 1;
      end
      seg_left[i] = seg_left[i] - 1;
      e.idx = i;
      e.val = level[i];
      exp_q.push_back(e);
    end
  end

  // Monitor: every instance presents a fresh output after each edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (dout[e.idx] !== e.val) begin
        miscompares++;
        $display("FAIL out[%0d] @%0t: got %b expected %b", e.idx, $time, dout[e.idx], e.val);
      end
    end
  end

  task automatic wait_high(input int unsigned idx, input int unsigned budget);
    bit seen;
    seen = 1'b0;
    for (int unsigned k = 0; k < budget; k++) begin
      @(negedge clk);
      if (dout[idx] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_high[%0d]: got no rise within %0d cycles, required a rise", idx, budget);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    nv[0] = 16'd0;  nv[1] = 16'd1; nv[2] = 16'd2; nv[3] = 16'd3;
    nv[4] = 16'd4;  nv[5] = 16'd5; nv[6] = 16'd10; nv[7] = 16'd15;

    // Common release: all instances phase-aligned.
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;
    repeat (60) @(negedge clk);

    // N=3: single-cycle reset in the middle of a high phase.
    wait_high(3, 20);
    rst[3] = 1'b0;
    @(negedge clk);
    rst[3] = 1'b1;
    repeat (20) @(negedge clk);

    // N=2 restarted, then switched to 5 partway into a half-period.
    rst[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    repeat (2) @(negedge clk);
    nv[2] = 16'd5;
    repeat (40) @(negedge clk);

    // N=4: long reset, then re-release.
    rst[4] = 1'b0;
    repeat (50) @(negedge clk);
    rst[4] = 1'b1;
    repeat (40) @(negedge clk);

    // Random divisor changes and reset pulses.
    for (int unsigned c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) rst[i] = 1'b1;
      if ($urandom_range(7, 0) == 0) begin
        int unsigned r;
        r = $urandom_range(NI - 1, 0);
        nv[r] = (r == NI - 1) ? 16'($urandom_range(15, 0)) : 16'($urandom_range(12, 0));
      end
      if ($urandom_range(39, 0) == 0) rst[$urandom_range(NI - 1, 0)] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;

    // Close with the full-range 4-bit divisor to see a clean 16-edge half-period.
    nv[7] = 16'd15;
    repeat (70) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_div.md
# freq_div

Programmable clock-enable style frequency divider. It produces a 50 %-duty square wave on `out` whose period is 2·(N+1) cycles of `clk`. The divisor `N` is a run-time input. The block sits alongside the acquisition timing logic and derives slower sample and strobe clocks from the main system clock.

## Interface
- `N_WIDTH`, default 16: width of the divisor input and of the internal counter.
- `clk`  input  1: system clock; all logic is rising-edge triggered.
- `reset`  input  1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `N`  input  N_WIDTH: divisor select, unsigned. The output half-period is N+1 `clk` cycles.
- `out`  output  1: divided square wave, registered.

## Operation
- Internal state:
  - `count`, N_WIDTH bits.
  - `n_act`, N_WIDTH bits: the active divisor.
  - `out` register.
- Reset (`reset`==0 at a rising edge):
  - `count`<=0, `out`<=0, `n_act`<=`N`.
  - Reset dominates all other activity.
- Run (`reset`==1 at a rising edge):
  - If `count`==`n_act`: `count`<=0, `out`<=~`out`, `n_act`<=`N` (new divisor is latched only at the wrap).
  - Otherwise: `count`<=`count`+1.
- N=0: `out` toggles on every edge, giving clk/2.
- N=1: clk/4. N=k: clk/(2k+2).
- Duty cycle is exactly 50 % for every N. The high and low phases are each N+1 cycles.
- Changing `N` mid-period has no effect until the current half-period completes. `count` therefore can never overshoot `n_act`, so there is no wrap-around hazard.
- N = 2^N_WIDTH−1 is legal. `count` reaches the all-ones value and then wraps to 0 through the compare, not through overflow.
- `out` is a registered flop output and is glitch-free. There is no combinational path from `N` to `out`.

## Timing
- `out` is 0 throughout reset and during the first N+1 run edges.
- First rising edge of `out`: the (N+1)th `clk` rising edge with `reset`==1.
- Later toggles occur every N+1 edges after that.
- Asserting reset mid-period: at the next rising edge, `out` is forced to 0 and the count restarts from 0. There is no partial-period completion.
- Deasserting reset: the first run edge is the edge at which `reset` is sampled high.
- Latency from an `N` change to the new period: the change takes effect at the next wrap, at most old N+1 edges later.

## Structure
- Single module, no sub-modules.
- A shared timing package holds the `N_WIDTH` default constant, so every divider instance in the design agrees on the width.
- Multiple instances with different `N` run concurrently and independently. They are phase-aligned only when released from the same reset edge.

## Test plan
- Release reset with N=0: `out` is 0,1,0,1… on successive edges, i.e. a period of 2 clk.
- Seven parallel instances with N=0,1,2,3,4,5,10, released together: `out` periods are 2,4,6,8,10,12,22 clk respectively. Each first rises at run edge N+1, and all are 50 % duty.
- N=3 running, reset asserted mid-high-phase for 1 cycle: `out`=0 on the next edge. After release, the first rise is exactly 4 edges later.
- N=2, change to N=5 two edges into a half-period: the current half-period still lasts 3 edges, and subsequent half-periods last 6.
- N=4, reset held low for 50 clk: `out` stays 0 and `count` stays 0. Re-release reproduces the same waveform as the first release.
- N=2^N_WIDTH−1, reduced to N_WIDTH=4 for simulation (N=15): half-period of 16 edges, with no early toggle from counter overflow.
